// File: rtl/rate_strobe_gen.sv
// rate_strobe_gen: run-time programmable clock-enable strobe with start/stop, one-shot mode and boundary-aligned limit updates
module rate_strobe_gen #(
    parameter int          NB_COUNT      = 32,
    parameter int unsigned DEFAULT_LIMIT = 10
) (
    input  logic                clock,
    input  logic                i_reset,
    input  logic                i_enable,
    input  logic                i_start,
    input  logic                i_stop,
    input  logic                i_mode,
    input  logic                i_load,
    input  logic [NB_COUNT-1:0] i_limit,
    output logic                o_enable,
    output logic                o_done,
    output logic                o_busy,
    output logic                o_pending,
    output logic [NB_COUNT-1:0] o_count
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t              state, state_n;
    logic [NB_COUNT-1:0] count, count_n, limit_active, active_n, limit_pending, pending_n;
    logic                mode, mode_n, enable_n, done_n, pend_flag_n;
    logic [NB_COUNT-1:0] boundary_limit;

    if (64'(DEFAULT_LIMIT) >= (64'd1 << NB_COUNT)) begin : g_limit_check
        $error("DEFAULT_LIMIT does not fit in NB_COUNT bits");
    end

    // limit to adopt at a period boundary: a same-edge load beats an older pending value
    assign boundary_limit = i_load ? i_limit : (o_pending ? limit_pending : limit_active);

    // next-state and registered-output decode; stop outranks wrap and start
    always_comb begin
        state_n     = state;
        count_n     = count;
        active_n    = limit_active;
        pending_n   = limit_pending;
        pend_flag_n = o_pending;
        mode_n      = mode;
        enable_n    = 1'b0;
        done_n      = 1'b0;
        if (state == IDLE) begin
            if (i_load) active_n = i_limit;
            if (i_start && !i_stop) begin
                state_n = RUN;
                count_n = '0;
                mode_n  = i_mode;
            end
        end else if (i_stop) begin
            state_n     = IDLE;
            count_n     = '0;
            active_n    = boundary_limit;
            pend_flag_n = 1'b0;
        end else if (i_enable && count == limit_active) begin
            count_n     = '0;
            enable_n    = 1'b1;
            active_n    = boundary_limit;
            pend_flag_n = 1'b0;
            if (mode) begin
                state_n = IDLE;
                done_n  = 1'b1;
            end
        end else begin
            if (i_enable) count_n = count + NB_COUNT'(1);
            if (i_load) begin
                pending_n   = i_limit;
                pend_flag_n = 1'b1;
            end
        end
    end

    // state, counter, limits and strobes; reset aborts a run with no strobe
    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            state         <= IDLE;
            count         <= '0;
            limit_active  <= NB_COUNT'(DEFAULT_LIMIT);
            limit_pending <= '0;
            mode          <= 1'b0;
            o_enable      <= 1'b0;
            o_done        <= 1'b0;
            o_pending     <= 1'b0;
        end else begin
            state         <= state_n;
            count         <= count_n;
            limit_active  <= active_n;
            limit_pending <= pending_n;
            mode          <= mode_n;
            o_enable      <= enable_n;
            o_done        <= done_n;
            o_pending     <= pend_flag_n;
        end
    end

    assign o_busy  = state == RUN;
    assign o_count = count;
endmodule

// File: tb/tb_rate_strobe_gen.sv
// tb_rate_strobe_gen: directed scoreboard bench for rate_strobe_gen
module tb_rate_strobe_gen;
    logic        clock = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_enable = 1'b0, i_start = 1'b0, i_stop = 1'b0, i_mode = 1'b0, i_load = 1'b0;
    logic [31:0] i_limit = '0;
    logic        o_enable, o_done, o_busy, o_pending;
    logic [31:0] o_count;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        string tag;
        logic  en, done, busy, pend;
        int    cnt;
    } exp_t;

    exp_t q[$];

    rate_strobe_gen #(.NB_COUNT(32), .DEFAULT_LIMIT(10)) dut (
        .clock(clock), .i_reset(i_reset), .i_enable(i_enable), .i_start(i_start),
        .i_stop(i_stop), .i_mode(i_mode), .i_load(i_load), .i_limit(i_limit),
        .o_enable(o_enable), .o_done(o_done), .o_busy(o_busy), .o_pending(o_pending),
        .o_count(o_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // push expectation, clock once, pop and compare; pulse inputs drop after the edge
    task automatic cyc(input string tag, input logic en, done, busy, pend, input int cnt);
        exp_t e;
        q.push_back('{tag, en, done, busy, pend, cnt});
        @(posedge clock);
        #1;
        e = q.pop_front();
        chk({e.tag, ".en"}, 32'(o_enable), 32'(e.en));
        chk({e.tag, ".done"}, 32'(o_done), 32'(e.done));
        chk({e.tag, ".busy"}, 32'(o_busy), 32'(e.busy));
        chk({e.tag, ".pend"}, 32'(o_pending), 32'(e.pend));
        chk({e.tag, ".cnt"}, o_count, 32'(e.cnt));
        i_start = 1'b0;
        i_stop  = 1'b0;
        i_load  = 1'b0;
    endtask

    initial begin
        #12;
        chk("rst.en", 32'(o_enable), 0);
        chk("rst.busy", 32'(o_busy), 0);
        chk("rst.cnt", o_count, 0);
        i_reset = 1'b0;
        @(posedge clock);
        #1;
        // 1: continuous at default limit 10
        i_enable = 1'b1;
        i_start = 1'b1;
        cyc("t1_start", 0, 0, 1, 0, 0);
        for (int p = 0; p < 3; p++)
            for (int k = 1; k <= 11; k++) cyc("t1_run", k == 11, 0, 1, 0, k % 11);
        // 2: load 3 mid-period; current period keeps 11 cycles
        for (int k = 1; k <= 4; k++) cyc("t2_pre", 0, 0, 1, 0, k);
        i_load = 1'b1;
        i_limit = 3;
        cyc("t2_load", 0, 0, 1, 1, 5);
        for (int k = 6; k <= 10; k++) cyc("t2_hold", 0, 0, 1, 1, k);
        cyc("t2_wrap", 1, 0, 1, 0, 0);
        for (int p = 0; p < 2; p++)
            for (int k = 1; k <= 4; k++) cyc("t2_new", k == 4, 0, 1, 0, k % 4);
        // 3: one-shot limit 5 with enable toggling
        i_stop = 1'b1;
        cyc("t3_stop", 0, 0, 0, 0, 0);
        i_load = 1'b1;
        i_limit = 5;
        cyc("t3_load", 0, 0, 0, 0, 0);
        i_enable = 1'b0;
        i_start = 1'b1;
        i_mode = 1'b1;
        cyc("t3_start", 0, 0, 1, 0, 0);
        i_mode = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            i_enable = 1'b1;
            cyc("t3_on", i == 6, i == 6, i != 6, 0, i == 6 ? 0 : i);
            i_enable = 1'b0;
            cyc("t3_off", 0, 0, i != 6, 0, i == 6 ? 0 : i);
        end
        i_enable = 1'b1;
        for (int i = 0; i < 3; i++) cyc("t3_after", 0, 0, 0, 0, 0);
        // 4: stop beats wrap and start; start in RUN ignored
        i_start = 1'b1;
        cyc("t4_start", 0, 0, 1, 0, 0);
        for (int k = 1; k <= 5; k++) cyc("t4_run", 0, 0, 1, 0, k);
        i_stop = 1'b1;
        i_start = 1'b1;
        cyc("t4_stopwrap", 0, 0, 0, 0, 0);
        cyc("t4_idle", 0, 0, 0, 0, 0);
        i_start = 1'b1;
        cyc("t4_restart", 0, 0, 1, 0, 0);
        for (int k = 1; k <= 6; k++) begin
            if (k == 2) begin
                i_start = 1'b1;
                i_mode = 1'b1;
            end
            cyc("t4_rerun", k == 6, 0, 1, 0, k % 6);
        end
        i_mode = 1'b0;
        cyc("t4_cont", 0, 0, 1, 0, 1);
        i_stop = 1'b1;
        cyc("t4_stop", 0, 0, 0, 0, 0);
        // 5: limit 0 strobes every enabled cycle
        i_load = 1'b1;
        i_limit = 0;
        cyc("t5_load", 0, 0, 0, 0, 0);
        i_start = 1'b1;
        cyc("t5_start", 0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) cyc("t5_on", 1, 0, 1, 0, 0);
        i_enable = 1'b0;
        for (int i = 0; i < 3; i++) cyc("t5_off", 0, 0, 1, 0, 0);
        i_enable = 1'b1;
        for (int i = 0; i < 2; i++) cyc("t5_on2", 1, 0, 1, 0, 0);
        i_stop = 1'b1;
        cyc("t5_stop", 0, 0, 0, 0, 0);
        // 6: async reset mid-period discards pending and restores default limit
        i_load = 1'b1;
        i_limit = 9;
        cyc("t6_load", 0, 0, 0, 0, 0);
        i_start = 1'b1;
        cyc("t6_start", 0, 0, 1, 0, 0);
        for (int k = 1; k <= 7; k++) begin
            if (k == 3) begin
                i_load = 1'b1;
                i_limit = 2;
            end
            cyc("t6_run", 0, 0, 1, k >= 3, k);
        end
        #2;
        i_reset = 1'b1;
        #1;
        chk("t6_rst.en", 32'(o_enable), 0);
        chk("t6_rst.done", 32'(o_done), 0);
        chk("t6_rst.busy", 32'(o_busy), 0);
        chk("t6_rst.pend", 32'(o_pending), 0);
        chk("t6_rst.cnt", o_count, 0);
        #2;
        i_reset = 1'b0;
        @(posedge clock);
        #1;
        i_start = 1'b1;
        cyc("t6_restart", 0, 0, 1, 0, 0);
        for (int k = 1; k <= 11; k++) cyc("t6_default", k == 11, 0, 1, 0, k % 11);
        chk("queue_empty", 32'(q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
